code_serializer: RTL and testbench
==================================

// Module: code_serializer
// PURPOSE
//  Transmit end of the digital-safe serial link. Accepts an N-bit entry code over a
//  valid/ready handshake, shifts it MSB-first onto ser_valid/ser_data for the fsmml
//  checker, then waits for its unlock_valid verdict (or a timeout). Reports the result
//  upstream. Sits between keypad/host logic and fsmml; one code in flight at a time.
// PARAMETERS
//  N            4    code width in bits (must match fsmml)
//  RESP_TIMEOUT 16   max cycles in WAIT_RESP before declaring timeout (>=1)
//  GAP          2    idle cycles after a verdict before p_ready re-asserts (>=0)
// PORTS
//  clk           in   1  clock, all logic on rising edge
//  rst           in   1  synchronous reset, active-high
//  p_valid       in   1  upstream code valid
//  p_data        in   N  upstream code
//  p_ready       out  1  block can accept a code (combinational: state==IDLE)
//  ser_valid     out  1  serial bit valid, to fsmml
//  ser_data      out  1  serial bit, MSB first, to fsmml
//  unlock_valid  in   1  fsmml verdict strobe
//  unlock        in   1  fsmml: code correct
//  incorrect     in   1  fsmml: code wrong
//  result_valid  out  1  one-cycle verdict pulse upstream
//  result_pass   out  1  1 = unlocked; held until next result_valid
//  timeout       out  1  1 = verdict missing; held until next result_valid
//  busy          out  1  state != IDLE
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge): state=IDLE; ser_valid, ser_data, result_valid,
//    result_pass, timeout, shift reg, counters all 0. Mid-transfer reset aborts the
//    code; no further ser_valid; fsmml is reset by the same source.
//  - States: IDLE -> SHIFT -> WAIT_RESP -> GAP -> IDLE (GAP skipped when GAP=0).
//  - IDLE: p_ready=1. Handshake at edge k (p_valid&&p_ready): p_data -> shreg,
//    bit count=N, go SHIFT. p_data ignored without handshake.
//  - SHIFT: outputs registered. ser_valid=1, ser_data=shreg[N-1] for cycles k+1..k+N,
//    shreg shifts left each cycle; ser_valid is never deasserted mid-code.
//    After N bits -> WAIT_RESP; ser_valid=0, ser_data=0 from cycle k+N+1.
//  - WAIT_RESP: counter increments each cycle from 0. On unlock_valid=1: result_valid
//    pulses next cycle, result_pass=unlock, timeout=0. unlock&&incorrect both 1 is
//    treated as fail (result_pass=0). If counter reaches RESP_TIMEOUT with no verdict:
//    result_valid pulse, result_pass=0, timeout=1. Verdict and expiry on same cycle:
//    verdict wins. Then -> GAP.
//  - unlock_valid while IDLE/SHIFT/GAP is ignored (no result_valid).
//  - GAP: GAP cycles with p_ready=0, then IDLE.
//  - Min per-code turnaround: 1 + N + (verdict latency) + 1 + GAP cycles.
//  - Counters sized $clog2(max(N,RESP_TIMEOUT)+1); no wrap possible by construction.
// STRUCTURE
//  - safe_pkg: localparam CODE_W=4, typedef enum logic [1:0] {IDLE,SHIFT,WAIT_RESP,GAP}
//    ser_state_t, shared with fsmml.
//  - Sub-module piso_shreg #(N): load/shift enable, serial MSB out. FSM and response
//    timer remain in code_serializer.
// TESTING (bench instantiates code_serializer + fsmml, fsmml.rstn = ~rst)
//  1 Send 4'b1011 -> ser_data 1,0,1,1 on 4 consecutive ser_valid cycles; result_valid
//    pulse with result_pass=1, timeout=0.
//  2 Send 4'b1100 -> bits 1,1,0,0; result_pass=0, timeout=0.
//  3 Hold p_valid with 4'b1101 then 4'b0101 back-to-back -> second accepted only after
//    GAP cycles; p_ready=0 throughout; both fail, no bit interleaving.
//  4 Stub responder never asserts unlock_valid, RESP_TIMEOUT=16 -> result_valid exactly
//    16 cycles after WAIT_RESP entry, timeout=1, result_pass=0.
//  5 Assert rst after 2nd bit of 4'b1011 -> next cycle ser_valid=0, busy=0, p_ready=1,
//    no result_valid; resend 4'b1011 -> pass.
//  6 Spurious unlock_valid=1 during SHIFT from stub -> ignored; genuine verdict later
//    produces exactly one result_valid.

Source files
------------

// File: rtl/code_serializer_pkg.sv
// Shared definitions for the serial code link (serializer side and fsmml checker).
package code_serializer_pkg;

  localparam int CODE_W = 4;

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_RESP, GAP} ser_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/code_serializer_piso.sv
// Parallel-in serial-out shift register: loads a code, shifts left, presents the MSB.
module piso_shreg
  import code_serializer_pkg::*;
#(
  parameter int N = CODE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] din,
  output logic         sout
);

  logic [N-1:0] shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= shreg << 1;
    end
  end

  // Zeros shift in, so the line returns to 0 once the last bit has gone out.
  assign sout = shreg[N-1];

endmodule

// File: rtl/code_serializer.sv
// Transmit end of the serial code link: shifts one code out MSB-first, then waits
// for the checker verdict or a response timeout and reports it upstream.
//
//  state     | meaning
//  IDLE      | ready for a new code
//  SHIFT     | code bits on ser_valid/ser_data
//  WAIT_RESP | waiting for unlock_valid or timeout
//  GAP       | quiet period after a verdict
module code_serializer
  import code_serializer_pkg::*;
#(
  parameter int N            = CODE_W,
  parameter int RESP_TIMEOUT = 16,
  parameter int GAP          = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         p_valid,
  input  logic [N-1:0] p_data,
  output logic         p_ready,
  output logic         ser_valid,
  output logic         ser_data,
  input  logic         unlock_valid,
  input  logic         unlock,
  input  logic         incorrect,
  output logic         result_valid,
  output logic         result_pass,
  output logic         timeout,
  output logic         busy
);

  localparam int CW = $clog2(max2(max2(N, RESP_TIMEOUT), GAP) + 1);
  localparam logic [CW-1:0] BITS_INIT = CW'(N);
  localparam logic [CW-1:0] TO_LAST   = CW'(RESP_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST  = (GAP > 0) ? CW'(GAP - 1) : '0;
  localparam ser_state_t    POST_VERDICT = (GAP > 0) ? code_serializer_pkg::GAP : IDLE;

  ser_state_t    state;
  logic [CW-1:0] cnt;
  logic          load;
  logic          shift_en;

  assign p_ready  = (state == IDLE);
  assign busy     = (state != IDLE);
  assign load     = p_ready && p_valid;
  assign shift_en = (state == SHIFT);

  piso_shreg #(.N(N)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift_en),
    .din   (p_data),
    .sout  (ser_data)
  );

  // cnt counts remaining bits in SHIFT, elapsed cycles in WAIT_RESP and GAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ser_valid    <= 1'b0;
      result_valid <= 1'b0;
      result_pass  <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (p_valid) begin
            state     <= SHIFT;
            cnt       <= BITS_INIT;
            ser_valid <= 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == CW'(1)) begin
            ser_valid <= 1'b0;
            state     <= WAIT_RESP;
            cnt       <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        WAIT_RESP: begin
          // A verdict on the expiry cycle still counts as a verdict.
          if (unlock_valid) begin
            result_valid <= 1'b1;
            result_pass  <= unlock & ~incorrect;
            timeout      <= 1'b0;
            state        <= POST_VERDICT;
            cnt          <= '0;
          end else if (cnt == TO_LAST) begin
            result_valid <= 1'b1;
            result_pass  <= 1'b0;
            timeout      <= 1'b1;
            state        <= POST_VERDICT;
            cnt          <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        code_serializer_pkg::GAP: begin
          if (cnt == GAP_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_serializer.sv
// Scoreboard bench for code_serializer with a behavioural checker stub on the serial side.
module tb_code_serializer;
  import code_serializer_pkg::*;

  localparam int N  = 4;
  localparam int RT = 16;
  localparam int GP = 2;
  localparam logic [3:0] SECRET = 4'b1011;

  logic clk, rst;
  logic p_valid;
  logic [N-1:0] p_data;
  logic p_ready, ser_valid, ser_data;
  logic unlock_valid, unlock, incorrect;
  logic result_valid, result_pass, timeout, busy;

  code_serializer #(.N(N), .RESP_TIMEOUT(RT), .GAP(GP)) dut (
    .clk          (clk),
    .rst          (rst),
    .p_valid      (p_valid),
    .p_data       (p_data),
    .p_ready      (p_ready),
    .ser_valid    (ser_valid),
    .ser_data     (ser_data),
    .unlock_valid (unlock_valid),
    .unlock       (unlock),
    .incorrect    (incorrect),
    .result_valid (result_valid),
    .result_pass  (result_pass),
    .timeout      (timeout),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    logic       pass;
    logic       to;
    int         dly;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic void bound_fail(input string name, input int limit);
    compared++;
    mismatched++;
    $display("FAIL %s: no DUT response within %0d cycles, required one (t=%0t)", name, limit, $time);
  endfunction

  // Monitor: collects serial bits, pops the scoreboard on every result pulse.
  int         cyc = 0;
  logic [7:0] bits = '0;
  int         nbits = 0;
  int         last_bit = 0;
  int         gap_at = 0;
  bit         gchk = 0;
  exp_t       got;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst === 1'b1) begin
      nbits = 0;
      gchk  = 0;
    end else begin
      if (gchk) begin
        if (cyc < gap_at) chk("gap_p_ready_low", p_ready, 0);
        else begin
          chk("gap_p_ready_high", p_ready, 1);
          gchk = 0;
        end
      end
      if (ser_valid === 1'b1) begin
        bits     = {bits[6:0], ser_data};
        nbits++;
        last_bit = cyc;
      end
      if (result_valid === 1'b1) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_result: got result_valid with pass=%0b, required none (t=%0t)",
                   result_pass, $time);
        end else begin
          got = sb.pop_front();
          chk("bit_count", nbits, N);
          chk("code_bits", bits[3:0], got.code);
          chk("result_pass", result_pass, got.pass);
          chk("timeout", timeout, got.to);
          chk("verdict_delay", cyc - last_bit, got.dly);
          chk("p_ready_at_result", p_ready, 0);
          gap_at = cyc + GP;
          gchk   = 1;
        end
        nbits = 0;
      end
    end
  end

  // Drives one code and plays the checker: counts bits, answers after lat cycles.
  task automatic send_code(input logic [3:0] code, input int lat, input bit silent,
                           input bit spur, input bit abort, input bit hold,
                           input logic [3:0] nxt);
    int   wd;
    int   nb;
    bit   verdict;
    exp_t e;
    p_valid = 1'b1;
    p_data  = code;
    wd = 0;
    while (p_ready !== 1'b1 && wd < 100) begin
      @(negedge clk);
      wd++;
    end
    if (wd >= 100) begin
      bound_fail("handshake_wait", 100);
      p_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (!abort) begin
      verdict = !silent && lat >= 1 && lat <= RT;
      e.code  = code;
      e.pass  = verdict && (code == SECRET);
      e.to    = !verdict;
      e.dly   = verdict ? lat + 1 : RT + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    if (hold) p_data = nxt;
    else begin
      p_valid = 1'b0;
      p_data  = 4'($urandom);
    end
    nb = 0;
    wd = 0;
    while (wd < 50) begin
      unlock_valid = 1'b0;
      unlock       = 1'b0;
      incorrect    = 1'b0;
      if (ser_valid === 1'b1) nb++;
      if (nb == N) break;
      if (abort && nb == 2) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ser_valid", ser_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_p_ready", p_ready, 1);
        return;
      end
      if (spur && nb == 2) begin
        unlock_valid = 1'b1;
        unlock       = 1'b1;
      end
      @(negedge clk);
      wd++;
    end
    if (nb != N) bound_fail("serial_bits_wait", 50);
    if (!silent) begin
      repeat (lat) @(negedge clk);
      unlock_valid = 1'b1;
      unlock       = (code == SECRET) ? 1'b1 : 1'($urandom);
      incorrect    = (code != SECRET);
      @(negedge clk);
      unlock_valid = 1'b0;
      unlock       = 1'b0;
      incorrect    = 1'b0;
    end
    wd = 0;
    while (busy !== 1'b0 && wd < 200) begin
      @(negedge clk);
      wd++;
    end
    if (wd >= 200) bound_fail("idle_wait", 200);
  endtask

  logic [3:0] rc;
  int         rl;
  bit         rs, rp;

  initial begin
    rst = 1'b1;
    p_valid = 1'b0;
    p_data = '0;
    unlock_valid = 1'b0;
    unlock = 1'b0;
    incorrect = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_p_ready", p_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ser_valid", ser_valid, 0);
    chk("rst_ser_data", ser_data, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result_pass", result_pass, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;
    @(negedge clk);

    send_code(4'b1011, 3, 0, 0, 0, 0, 4'b0000);
    send_code(4'b1100, 5, 0, 0, 0, 0, 4'b0000);
    send_code(4'b1101, 2, 0, 0, 0, 1, 4'b0101);
    send_code(4'b0101, 2, 0, 0, 0, 0, 4'b0000);
    send_code(4'b1011, 1, 1, 0, 0, 0, 4'b0000);
    send_code(4'b1011, 4, 0, 0, 1, 0, 4'b0000);
    send_code(4'b1011, 4, 0, 0, 0, 0, 4'b0000);
    send_code(4'b0110, 6, 0, 1, 0, 0, 4'b0000);
    send_code(4'b1011, 16, 0, 0, 0, 0, 4'b0000);
    send_code(4'b1011, 17, 0, 0, 0, 0, 4'b0000);
    send_code(4'b1011, 1, 0, 1, 0, 0, 4'b0000);

    for (int i = 0; i < 40; i++) begin
      rc = ($urandom % 4 == 0) ? SECRET : 4'($urandom);
      rl = $urandom_range(1, 20);
      rs = ($urandom % 8 == 0);
      rp = ($urandom % 4 == 0);
      send_code(rc, rl, rs, rp, 0, 0, 4'b0000);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running at t=%0t, required completion", $time);
    $fatal(1, "global timeout");
  end

endmodule
